count_seq_monitor: RTL and testbench
====================================

Name: count_seq_monitor

Overview:
- Consumer/checker on the output side of the 4-bit free-running counter: samples the counter value every valid cycle and verifies it follows the expected +1 modulo-2^WIDTH sequence.
- Locks onto the stream, flags sequence breaks, counts errors and reports wrap events.
- Sits beside the counter in the lab top-level and drives status LEDs and the seven-segment error display.

Parameters:
- WIDTH, 4, width of the monitored counter value.
- LOCK_N, 3, consecutive correct increments required to declare lock (1..15).
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  single system clock, rising-edge.
- reset  input  1  synchronous, active-low reset (one clock; reset is synchronous and active-low).
- q  input  WIDTH  counter value under observation.
- q_valid  input  1  q is sampled only when high.
- locked  output  1  high while in LOCKED state.
- err_pulse  output  1  one-cycle pulse on a sequence break detected while LOCKED.
- err_count  output  ERR_W  saturating count of err_pulse events.
- wrap_pulse  output  1  one-cycle pulse when a correct max->0 transition is seen while LOCKED.
- last_q  output  WIDTH  most recently sampled q.

Behaviour:
- All state updates on rising clk; reset sampled only at the edge (reset==0 -> reset).
- Reset values: locked=0, err_pulse=0, err_count=0, wrap_pulse=0, last_q=0, state=IDLE, match_cnt=0.
- States: IDLE (no sample yet), HUNT (have reference, counting matches), LOCKED.
- expected = last_q + 1, truncated to WIDTH bits, so 2^WIDTH-1 -> 0 is correct.
- q_valid=0: no state change, and pulses are 0 that cycle. A gap does not break lock.
- IDLE, valid: last_q<=q; go to HUNT; match_cnt<=0.
- HUNT, valid:
  - last_q<=q.
  - q==expected: match_cnt+1. If it reaches LOCK_N, go to LOCKED and clear match_cnt.
  - Otherwise match_cnt<=0 and stay in HUNT. No err_pulse in HUNT.
- LOCKED, valid:
  - last_q<=q.
  - q==expected: stay. wrap_pulse=1 next cycle if last_q==all-ones and q==0.
  - Mismatch: err_pulse=1 next cycle, err_count+1 (saturate at 2^ERR_W-1), go to HUNT with match_cnt<=0.
- Output timing: outputs are registered, with latency 1 cycle from the sampling edge. locked goes high on the same edge that enters LOCKED.
- q repeating the same value (counter held in reset) counts as a mismatch.
- Reset asserted mid-lock: everything returns to reset values at that edge, including err_count.
- err_count at saturation: further errors still pulse err_pulse, but the count holds.

Optional Feature:
- Macro CNT_MON_DIR_EN.
- Defined: adds input dir (1 bit, 1=up, 0=down). expected = last_q+1 when dir=1, else last_q-1, mod 2^WIDTH. wrap_pulse fires on all-ones->0 (up) or 0->all-ones (down). A change of dir while LOCKED is legal and does not break lock, provided the sample matches the new direction.
- Undefined: no dir port, up-only checking.

Decomposition:
- Package count_mon_pkg holds:
  - state enum {IDLE, HUNT, LOCKED}
  - default WIDTH/LOCK_N/ERR_W localparams
  - a function next_expected(value, dir)
- One sub-module: sat_counter (parameterized width, inc input, synchronous active-low clear), used for err_count.

Test Plan:
- Reset then q=0,1,2,3 valid each cycle -> locked rises after 4th sample (3 matches), err_count=0.
- Locked, then q=...,14,15,0,1 -> wrap_pulse single cycle after 0 sampled, locked stays 1.
- Locked at q=5, inject q=9 -> err_pulse one cycle, err_count=1, locked=0. Then 10,11,12 -> locked=1 again.
- Locked, q_valid low 5 cycles, then next value in sequence -> no error, locked stays 1.
- ERR_W=2: force 5 breaks -> err_count sticks at 3, err_pulse fires all 5 times. Reset low one edge mid-stream -> all outputs 0.
- With CNT_MON_DIR_EN: up-lock at 7, dir=0, then q=6,5 -> no error. Then q=0->15 in down mode -> wrap_pulse.

Source files
------------

// File: rtl/count_mon_pkg.sv
// rtl/count_mon_pkg.sv - shared types, defaults and next-value helper for count_seq_monitor
package count_mon_pkg;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_LOCK_N = 3;
  localparam int DEF_ERR_W  = 8;
  localparam int EXP_W      = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Callers truncate the result to their own width, which gives the modulo wrap for free.
  function automatic logic [EXP_W-1:0] next_expected(input logic [EXP_W-1:0] value,
                                                     input logic             dir);
    return dir ? value + EXP_W'(1) : value - EXP_W'(1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up counter with synchronous active-low clear
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/count_seq_monitor.sv
// rtl/count_seq_monitor.sv - locks onto a +1 counter stream, flags breaks, counts errors, reports wraps
// Optional macro CNT_MON_DIR_EN adds a dir input for up/down checking.
module count_seq_monitor
  import count_mon_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int LOCK_N = DEF_LOCK_N,
  parameter int ERR_W  = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] q,
  input  logic             q_valid,
`ifdef CNT_MON_DIR_EN
  input  logic             dir,
`endif
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic             wrap_pulse,
  output logic [WIDTH-1:0] last_q
);

  localparam logic [3:0] LOCK_TH = 4'(LOCK_N);

  state_t           state;
  logic [3:0]       match_cnt;
  logic             dir_up;
  logic [WIDTH-1:0] expected;
  logic             match;
  logic             at_wrap;
  logic             err_event;

`ifdef CNT_MON_DIR_EN
  assign dir_up = dir;
`else
  assign dir_up = 1'b1;
`endif

  assign expected  = WIDTH'(next_expected(EXP_W'(last_q), dir_up));
  assign match     = (q == expected);
  // A matching sample from the boundary value is by definition the wrap transition.
  assign at_wrap   = dir_up ? (last_q == {WIDTH{1'b1}}) : (last_q == {WIDTH{1'b0}});
  assign err_event = q_valid && (state == LOCKED) && !match;

  assign locked = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      match_cnt  <= 4'd0;
      last_q     <= '0;
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
      if (q_valid) begin
        last_q <= q;
        case (state)
          IDLE: begin
            state     <= HUNT;
            match_cnt <= 4'd0;
          end
          HUNT: begin
            if (match) begin
              if (match_cnt + 4'd1 >= LOCK_TH) begin
                state     <= LOCKED;
                match_cnt <= 4'd0;
              end else begin
                match_cnt <= match_cnt + 4'd1;
              end
            end else begin
              match_cnt <= 4'd0;
            end
          end
          LOCKED: begin
            if (match) begin
              wrap_pulse <= at_wrap;
            end else begin
              err_pulse <= 1'b1;
              state     <= HUNT;
              match_cnt <= 4'd0;
            end
          end
          default: begin
            state     <= IDLE;
            match_cnt <= 4'd0;
          end
        endcase
      end
    end
  end

  sat_counter #(
    .W(ERR_W)
  ) u_err_cnt (
    .clk  (clk),
    .clr_n(reset),
    .inc  (err_event),
    .count(err_count)
  );

endmodule

// File: tb/tb_count_seq_monitor.sv
// tb/tb_count_seq_monitor.sv - directed self-checking bench for count_seq_monitor
module tb_count_seq_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] q;
  logic       q_valid;
  logic       dir;

  logic       locked, err_pulse, wrap_pulse;
  logic [7:0] err_count;
  logic [3:0] last_q;
  logic       locked2, err_pulse2, wrap_pulse2;
  logic [1:0] err_count2;
  logic [3:0] last_q2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  count_seq_monitor #(.WIDTH(4), .LOCK_N(3), .ERR_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .q         (q),
    .q_valid   (q_valid),
`ifdef CNT_MON_DIR_EN
    .dir       (dir),
`endif
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .wrap_pulse(wrap_pulse),
    .last_q    (last_q)
  );

  count_seq_monitor #(.WIDTH(4), .LOCK_N(3), .ERR_W(2)) dut2 (
    .clk       (clk),
    .reset     (reset),
    .q         (q),
    .q_valid   (q_valid),
`ifdef CNT_MON_DIR_EN
    .dir       (dir),
`endif
    .locked    (locked2),
    .err_pulse (err_pulse2),
    .err_count (err_count2),
    .wrap_pulse(wrap_pulse2),
    .last_q    (last_q2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic [3:0] v, input logic val);
    q       = v;
    q_valid = val;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] v;
    reset   = 1'b0;
    q       = 4'd0;
    q_valid = 1'b0;
    dir     = 1'b1;
    send(4'd0, 1'b0);
    send(4'd0, 1'b0);
    check("rst_locked", locked, 0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_err_count", err_count, 0);
    check("rst_wrap", wrap_pulse, 0);
    check("rst_last_q", last_q, 0);
    reset = 1'b1;

    // Lock: reference 0, then three matches.
    send(4'd0, 1'b1);
    send(4'd1, 1'b1);
    send(4'd2, 1'b1);
    check("lock_not_yet", locked, 0);
    send(4'd3, 1'b1);
    check("lock_rise", locked, 1);
    check("lock_err_count", err_count, 0);
    check("lock_last_q", last_q, 3);

    for (int i = 4; i <= 15; i++) send(4'(i), 1'b1);
    check("pre_wrap", wrap_pulse, 0);
    check("pre_wrap_last_q", last_q, 15);
    send(4'd0, 1'b1);
    check("wrap_pulse", wrap_pulse, 1);
    check("wrap_locked", locked, 1);
    send(4'd1, 1'b1);
    check("wrap_single", wrap_pulse, 0);
    check("wrap_locked2", locked, 1);

    // Break while locked at 5.
    for (int i = 2; i <= 5; i++) send(4'(i), 1'b1);
    send(4'd9, 1'b1);
    check("brk_err_pulse", err_pulse, 1);
    check("brk_err_count", err_count, 1);
    check("brk_locked", locked, 0);
    check("brk_last_q", last_q, 9);
    send(4'd10, 1'b1);
    check("brk_pulse_single", err_pulse, 0);
    send(4'd11, 1'b1);
    send(4'd12, 1'b1);
    check("relock", locked, 1);

    // Gap in valid keeps lock and ignores q.
    for (int i = 0; i < 5; i++) send(4'd7, 1'b0);
    check("gap_locked", locked, 1);
    check("gap_last_q", last_q, 12);
    send(4'd13, 1'b1);
    check("gap_resume_err", err_pulse, 0);
    check("gap_resume_locked", locked, 1);
    check("gap_err_count", err_count, 1);

    // Repeated value is a break.
    send(4'd13, 1'b1);
    check("repeat_err_pulse", err_pulse, 1);
    check("repeat_err_count", err_count, 2);

    // Five more breaks: narrow counter saturates at 3, pulses keep firing.
    v = 4'd13;
    for (int k = 0; k < 5; k++) begin
      send(v + 4'd1, 1'b1);
      send(v + 4'd2, 1'b1);
      send(v + 4'd3, 1'b1);
      check("sat_relock", locked2, 1);
      send(v + 4'd3, 1'b1);
      check("sat_err_pulse2", err_pulse2, 1);
      v = v + 4'd3;
    end
    check("sat_err_count2", err_count2, 3);
    check("sat_err_count8", err_count, 7);

    // Reset for one edge mid-lock.
    send(v + 4'd1, 1'b1);
    send(v + 4'd2, 1'b1);
    send(v + 4'd3, 1'b1);
    check("prerst_locked", locked, 1);
    reset = 1'b0;
    send(v + 4'd4, 1'b1);
    check("midrst_locked", locked, 0);
    check("midrst_err_count", err_count, 0);
    check("midrst_err_count2", err_count2, 0);
    check("midrst_last_q", last_q, 0);
    check("midrst_pulses", {err_pulse, wrap_pulse}, 0);
    reset = 1'b1;

    // Mismatch while hunting raises no error.
    send(4'd5, 1'b1);
    send(4'd8, 1'b1);
    check("hunt_no_err", err_pulse, 0);
    check("hunt_err_count", err_count, 0);
    send(4'd4, 1'b1);
    send(4'd5, 1'b1);
    send(4'd6, 1'b1);
    send(4'd7, 1'b1);
    check("lock_at_7", locked, 1);

`ifdef CNT_MON_DIR_EN
    dir = 1'b0;
    send(4'd6, 1'b1);
    send(4'd5, 1'b1);
    check("down_no_err", err_pulse, 0);
    check("down_locked", locked, 1);
    for (int i = 4; i >= 0; i--) send(4'(i), 1'b1);
    check("down_pre_wrap", wrap_pulse, 0);
    send(4'd15, 1'b1);
    check("down_wrap", wrap_pulse, 1);
    check("down_err_count", err_count, 0);
    dir = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
